// File: rtl/line_draw_ctrl.sv
// line_draw_ctrl
//   Memory-mapped register front end for the line-drawing peripheral. It holds
//   the endpoint, colour and mode registers, launches the Bresenham core with a
//   go/done handshake and reports status back to the processor. In stall mode
//   (MODE=0) any bus access made while a line is being drawn is held off with
//   waitrequest. In poll mode (MODE=1) the bus is never stalled.
//
//   Optional feature macro: LINE_DRAW_CTRL_IRQ_EN (adds irq port + STATUS bit2 irq_en)
//
// Ports
//   clock, reset_n          system clock (posedge), synchronous active-low reset
//   address[2:0]            0 MODE, 1 STATUS, 2 GO, 3 START, 4 END, 5 COLOR
//   write, read, writedata  Avalon-MM slave request
//   readdata, waitrequest   Avalon-MM slave response (readdata combinational)
//   core_go                 one-cycle launch pulse to the core
//   core_x0/y0/x1/y1/color  launch copies held stable for the core
//   core_done               one-cycle completion pulse from the core
//   irq                     (macro only) done_sticky & irq_en, registered
module line_draw_ctrl #(
  parameter int X_W     = 9,
  parameter int Y_W     = 8,
  parameter int COLOR_W = 3
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [2:0]         address,
  input  logic               write,
  input  logic               read,
  input  logic [31:0]        writedata,
  output logic [31:0]        readdata,
  output logic               waitrequest,
  output logic               core_go,
  output logic [X_W-1:0]     core_x0,
  output logic [Y_W-1:0]     core_y0,
  output logic [X_W-1:0]     core_x1,
  output logic [Y_W-1:0]     core_y1,
  output logic [COLOR_W-1:0] core_color,
  input  logic               core_done
`ifdef LINE_DRAW_CTRL_IRQ_EN
  ,
  output logic               irq
`endif
);

  localparam logic [2:0] A_MODE   = 3'd0;
  localparam logic [2:0] A_STATUS = 3'd1;
  localparam logic [2:0] A_GO     = 3'd2;
  localparam logic [2:0] A_START  = 3'd3;
  localparam logic [2:0] A_END    = 3'd4;
  localparam logic [2:0] A_COLOR  = 3'd5;

  typedef enum logic [1:0] {IDLE, LAUNCH, BUSY} state_t;

  state_t               state;
  logic                 mode;
  logic                 done_sticky;
  logic [X_W-1:0]       start_x, end_x;
  logic [Y_W-1:0]       start_y, end_y;
  logic [COLOR_W-1:0]   color;
  logic                 irq_en;

  logic busy, wr_acc, go_launch, status_wr, done_evt;
  logic unused_wd;

  assign busy        = (state != IDLE);
  // Only stall mode holds the bus; in IDLE nothing is ever stalled, so the
  // launching GO write always goes straight through.
  assign waitrequest = (read | write) & busy & ~mode;
  assign wr_acc      = write & ~waitrequest;
  assign go_launch   = wr_acc & (address == A_GO) & (state == IDLE);
  assign status_wr   = wr_acc & (address == A_STATUS);
  assign done_evt    = core_done & (state == BUSY);
  assign unused_wd   = ^writedata;

  always_comb begin
    readdata = '0;
    case (address)
      A_MODE:   readdata[0] = mode;
      A_STATUS: begin
        readdata[0] = busy;
        readdata[1] = done_sticky;
        readdata[2] = irq_en;
      end
      A_START: begin
        readdata[X_W-1:0]     = start_x;
        readdata[X_W+Y_W-1:X_W] = start_y;
      end
      A_END: begin
        readdata[X_W-1:0]     = end_x;
        readdata[X_W+Y_W-1:X_W] = end_y;
      end
      A_COLOR:  readdata[COLOR_W-1:0] = color;
      default:  readdata = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= IDLE;
      core_go     <= 1'b0;
      core_x0     <= '0;
      core_y0     <= '0;
      core_x1     <= '0;
      core_y1     <= '0;
      core_color  <= '0;
      mode        <= 1'b0;
      done_sticky <= 1'b0;
      start_x     <= '0;
      start_y     <= '0;
      end_x       <= '0;
      end_y       <= '0;
      color       <= '0;
      irq_en      <= 1'b0;
    end else begin
      // Launch FSM. The launch copies are captured on the accepting edge so
      // that later register writes (poll mode) never disturb a line in flight.
      case (state)
        IDLE: begin
          core_go <= 1'b0;
          if (go_launch) begin
            state      <= LAUNCH;
            core_go    <= 1'b1;
            core_x0    <= start_x;
            core_y0    <= start_y;
            core_x1    <= end_x;
            core_y1    <= end_y;
            core_color <= color;
          end
        end
        LAUNCH: begin
          core_go <= 1'b0;
          state   <= BUSY;
        end
        BUSY: begin
          core_go <= 1'b0;
          if (done_evt) state <= IDLE;
        end
        default: begin
          core_go <= 1'b0;
          state   <= IDLE;
        end
      endcase

      if (wr_acc) begin
        case (address)
          A_MODE:  mode <= writedata[0];
          A_START: begin
            start_x <= writedata[X_W-1:0];
            start_y <= writedata[X_W+Y_W-1:X_W];
          end
          A_END: begin
            end_x <= writedata[X_W-1:0];
            end_y <= writedata[X_W+Y_W-1:X_W];
          end
          A_COLOR: color <= writedata[COLOR_W-1:0];
          default: ;
        endcase
      end

`ifdef LINE_DRAW_CTRL_IRQ_EN
      if (status_wr) irq_en <= writedata[2];
`endif

      // A completion on the same edge as a clear wins, so it is never lost.
      if (done_evt)                    done_sticky <= 1'b1;
      else if (go_launch || status_wr) done_sticky <= 1'b0;
    end
  end

`ifdef LINE_DRAW_CTRL_IRQ_EN
  // irq follows done_sticky one cycle later but drops on the same edge as
  // the clear so software never sees a stale interrupt after acknowledging.
  always_ff @(posedge clock) begin
    if (!reset_n)
      irq <= 1'b0;
    else if ((go_launch || status_wr) && !done_evt)
      irq <= 1'b0;
    else
      irq <= done_sticky & irq_en;
  end
`endif

endmodule

// File: tb/tb_line_draw_ctrl.sv
module tb_line_draw_ctrl;
  localparam int X_W = 9, Y_W = 8, COLOR_W = 3;

  logic clock = 1'b0, reset_n = 1'b0;
  logic [2:0] address = '0;
  logic write = 1'b0, read = 1'b0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic waitrequest, core_go, core_done = 1'b0;
  logic [X_W-1:0] core_x0, core_x1;
  logic [Y_W-1:0] core_y0, core_y1;
  logic [COLOR_W-1:0] core_color;
`ifdef LINE_DRAW_CTRL_IRQ_EN
  logic irq;
`endif

  line_draw_ctrl #(.X_W(X_W), .Y_W(Y_W), .COLOR_W(COLOR_W)) dut (
    .clock(clock), .reset_n(reset_n), .address(address), .write(write),
    .read(read), .writedata(writedata), .readdata(readdata),
    .waitrequest(waitrequest), .core_go(core_go), .core_x0(core_x0),
    .core_y0(core_y0), .core_x1(core_x1), .core_y1(core_y1),
    .core_color(core_color), .core_done(core_done)
`ifdef LINE_DRAW_CTRL_IRQ_EN
    , .irq(irq)
`endif
  );

  always #5 clock = ~clock;

  int checks = 0, passed = 0;

  // Reference model state: the register file as software sees it, and the
  // expected launch copies the core should be holding.
  int m_sx, m_sy, m_ex, m_ey, m_col;
  int l_sx, l_sy, l_ex, l_ey, l_col;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] pack_xy(input int x, input int y);
    return (32'(y) << X_W) | 32'(x);
  endfunction

  // One bus transfer, held until accepted. Returns at accept edge + 1.
  task automatic bus(input logic [2:0] a, input logic wr, input logic [31:0] wd,
                     output logic [31:0] rd, output int waited);
    address = a; write = wr; read = ~wr; writedata = wd; waited = 0;
    @(negedge clock);
    while (waitrequest && waited < 500) begin
      waited++;
      @(negedge clock);
    end
    if (waited >= 500) chk("bus_timeout", 32'(waited), 32'd0);
    rd = readdata;
    @(posedge clock); #1;
    write = 1'b0; read = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] wd);
    logic [31:0] d; int w;
    bus(a, 1'b1, wd, d, w);
  endtask

  task automatic rd_chk(input string tag, input logic [2:0] a, input logic [31:0] exp);
    logic [31:0] d; int w;
    bus(a, 1'b0, '0, d, w);
    chk(tag, d, exp);
  endtask

  task automatic pulse_done(input int delay);
    repeat (delay) @(posedge clock);
    #1 core_done = 1'b1;
    @(posedge clock); #1 core_done = 1'b0;
  endtask

  task automatic set_regs(input int sx, input int sy, input int ex, input int ey, input int c);
    // Random junk above the packed fields must be ignored by the registers.
    wr(3'd3, ($urandom() << (X_W + Y_W)) | pack_xy(sx, sy));
    wr(3'd4, ($urandom() << (X_W + Y_W)) | pack_xy(ex, ey));
    wr(3'd5, ($urandom() & ~32'h7) | 32'(c));
    m_sx = sx; m_sy = sy; m_ex = ex; m_ey = ey; m_col = c;
  endtask

  task automatic go_and_check(input string tag);
    wr(3'd2, $urandom());
    l_sx = m_sx; l_sy = m_sy; l_ex = m_ex; l_ey = m_ey; l_col = m_col;
    chk({tag, "_go"}, 32'(core_go), 32'd1);
    chk({tag, "_x0"}, 32'(core_x0), 32'(l_sx));
    chk({tag, "_y0"}, 32'(core_y0), 32'(l_sy));
    chk({tag, "_x1"}, 32'(core_x1), 32'(l_ex));
    chk({tag, "_y1"}, 32'(core_y1), 32'(l_ey));
    chk({tag, "_col"}, 32'(core_color), 32'(l_col));
    @(posedge clock); #1;
    chk({tag, "_go_1cyc"}, 32'(core_go), 32'd0);
  endtask

  initial begin
    logic [31:0] d;
    int w, gos;

    // Reset
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    chk("rst_wait", 32'(waitrequest), 32'd0);
    chk("rst_go", 32'(core_go), 32'd0);
    rd_chk("rst_status", 3'd1, 32'd0);
    rd_chk("rst_mode", 3'd0, 32'd0);

    // Directed launch in stall mode
    set_regs(10, 20, 300, 200, 5);
    go_and_check("dir");
    fork
      pulse_done(50);
      bus(3'd1, 1'b0, '0, d, w);
    join
    chk("stall_status", d, 32'h2);
    chk("stall_seen", 32'(w >= 45 && w <= 52), 32'd1);
    rd_chk("rb_start", 3'd3, pack_xy(10, 20));
    rd_chk("rb_end", 3'd4, pack_xy(300, 200));
    rd_chk("rb_color", 3'd5, 32'd5);
    rd_chk("rb_go", 3'd2, 32'd0);
    wr(3'd6, 32'hFFFF_FFFF);
    rd_chk("rb_unmapped", 3'd6, 32'd0);
    rd_chk("unmapped_no_effect", 3'd3, pack_xy(10, 20));

    // Randomised draws in stall mode, checked against the model
    for (int i = 0; i < 6; i++) begin
      set_regs($urandom_range(319), $urandom_range(239), $urandom_range(319),
               $urandom_range(239), $urandom_range(7));
      rd_chk("rnd_rb_start", 3'd3, pack_xy(m_sx, m_sy));
      go_and_check("rnd");
      fork
        pulse_done($urandom_range(1, 20));
        bus(3'd1, 1'b0, '0, d, w);
      join
      chk("rnd_status", d, 32'h2);
    end

    // Poll mode
    wr(3'd0, 32'h1);
    rd_chk("poll_mode", 3'd0, 32'd1);
    set_regs(33, 44, 55, 66, 3);
    go_and_check("poll");
    bus(3'd1, 1'b0, '0, d, w);
    chk("poll_status", d, 32'h1);
    chk("poll_nowait", 32'(w), 32'd0);
    wr(3'd2, 32'h0);
    gos = 0;
    repeat (4) begin
      if (core_go) gos++;
      @(posedge clock); #1;
    end
    chk("poll_no_relaunch", 32'(gos), 32'd0);
    for (int i = 0; i < 3; i++) begin
      set_regs((i == 0) ? 0 : $urandom_range(319), (i == 0) ? 0 : $urandom_range(239),
               $urandom_range(319), $urandom_range(239), $urandom_range(7));
      chk("poll_keep_x0", 32'(core_x0), 32'(l_sx));
      chk("poll_keep_y0", 32'(core_y0), 32'(l_sy));
      chk("poll_keep_x1", 32'(core_x1), 32'(l_ex));
    end
    rd_chk("poll_reg_updated", 3'd4, pack_xy(m_ex, m_ey));

    // Simultaneous done and GO in poll mode: done wins, GO dropped
    address = 3'd2; write = 1'b1; writedata = '0; core_done = 1'b1;
    @(posedge clock); #1;
    write = 1'b0; core_done = 1'b0;
    gos = 0;
    repeat (3) begin
      if (core_go) gos++;
      @(posedge clock); #1;
    end
    chk("simul_no_launch", 32'(gos), 32'd0);
    rd_chk("simul_status", 3'd1, 32'h2);
    go_and_check("reissue");
    rd_chk("reissue_status", 3'd1, 32'h1);
    pulse_done(3);
    rd_chk("reissue_done", 3'd1, 32'h2);
    wr(3'd1, 32'h0);
    rd_chk("status_clear", 3'd1, 32'h0);

    // Reset mid-draw with a stalled read pending
    wr(3'd0, 32'h0);
    go_and_check("mid");
    address = 3'd1; read = 1'b1;
    @(negedge clock);
    chk("mid_stalled", 32'(waitrequest), 32'd1);
    reset_n = 1'b0;
    @(posedge clock); #1;
    chk("mid_rst_wait", 32'(waitrequest), 32'd0);
    read = 1'b0; reset_n = 1'b1;
    rd_chk("mid_rst_status", 3'd1, 32'h0);
    rd_chk("mid_rst_mode", 3'd0, 32'h0);

`ifdef LINE_DRAW_CTRL_IRQ_EN
    wr(3'd1, 32'h4);
    go_and_check("irq");
    pulse_done(5);
    chk("irq_set", 32'(irq), 32'd1);
    wr(3'd1, 32'h4);
    chk("irq_clear", 32'(irq), 32'd0);
    wr(3'd1, 32'h0);
    go_and_check("noirq");
    pulse_done(5);
    @(posedge clock); #1;
    chk("irq_off", 32'(irq), 32'd0);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1);
  end
endmodule
